// File: rtl/obuf_reader_if.sv
// Signal bundle between obuf_reader and its environment: start/len control,
// the byte-read memory port, the output byte stream and status.
interface obuf_reader_if #(
  parameter int ASZ = 17
);
  // Both handshakes complete on a rising edge where the requester's enable or
  // valid and the responder's grant or ready are high together. The requester
  // holds its address or data steady until that edge.
  logic           start;
  logic [ASZ-1:0] len;
  logic           mem_en;
  logic [ASZ-1:0] mem_a;
  logic           mem_gnt;
  logic [7:0]     mem_d;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic           done;
  logic [ASZ-1:0] count;

  modport master (
    input  start, len, mem_gnt, mem_d, tx_ready,
    output mem_en, mem_a, tx_data, tx_valid, busy, done, count
  );

  modport slave (
    output start, len, mem_gnt, mem_d, tx_ready,
    input  mem_en, mem_a, tx_data, tx_valid, busy, done, count
  );
endinterface

// File: rtl/obuf_reader.sv
// Drains a byte buffer from memory into a valid/ready byte stream, one byte
// per read/emit round trip, optionally stopping at a NUL byte.
module obuf_reader #(
  parameter logic [31:0] OBUF     = 32'h1400,
  parameter int          ASZ      = 17,
  parameter int          MAXLEN   = 'h600,
  parameter bit          NUL_STOP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  obuf_reader_if.master bus,
  output logic [2:0]   state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam logic [ASZ-1:0] OBUF_C   = OBUF[ASZ-1:0];
  localparam logic [ASZ-1:0] MAXLEN_C = ASZ'(MAXLEN);

  state_e         state_q;
  logic [ASZ-1:0] len_q;
  logic [ASZ-1:0] ptr_q;
  logic [ASZ-1:0] count_q;
  logic [7:0]     tx_data_q;
  logic           mem_en_q;
  logic           tx_valid_q;
  logic           busy_q;
  logic           done_q;

  logic [ASZ-1:0] len_d;
  logic [ASZ-1:0] count_d;

  always_comb begin
    len_d   = (bus.len > MAXLEN_C) ? MAXLEN_C : bus.len;
    count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      mem_en_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            count_q <= '0;
            len_q   <= len_d;
            ptr_q   <= OBUF_C;
            if (bus.len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= REQ;
              mem_en_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            mem_en_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          tx_data_q <= bus.mem_d;
          // A NUL terminator is consumed but never presented downstream.
          if (NUL_STOP && (bus.mem_d == 8'h00)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q    <= EMIT;
            tx_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            count_q    <= count_d;
            ptr_q      <= ptr_q + 1'b1;
            if (count_d == len_q) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= REQ;
              mem_en_q <= 1'b1;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          mem_en_q   <= 1'b0;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_a    = ptr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_obuf_reader.sv
// Bench for obuf_reader: directed buffer scenarios plus randomized transfers
// with random grant/ready throttling, checked against a buffer-walk model.
module tb_obuf_reader;

  localparam int ASZ      = 17;
  localparam int OBUF     = 'h1400;
  localparam int MAXLEN   = 'h600;
  localparam int MEMSZ    = 1 << ASZ;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_o;

  obuf_reader_if #(.ASZ(ASZ)) bus ();

  obuf_reader #(
    .OBUF(32'h1400), .ASZ(ASZ), .MAXLEN('h600), .NUL_STOP(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]     mem [0:MEMSZ-1];
  logic [7:0]     exp_q[$];
  logic [ASZ-1:0] exp_addr_q[$];
  int             exp_cnt;
  bit             end_by_len;
  int             n_checks = 0;
  int             n_err = 0;
  int             done_cnt = 0;
  int             xfer_cnt = 0;
  int             gnt_pct = 100;
  int             rdy_pct = 100;
  int             gnt_block = 0;
  int             rdy_block = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the buffer from OBUF for min(len, MAXLEN) bytes, stopping
  // at the first NUL (which is read but not emitted).
  function automatic void build_model(input int len_v);
    int l;
    logic [7:0] b;
    exp_q.delete();
    exp_addr_q.delete();
    exp_cnt    = 0;
    end_by_len = 1'b0;
    l = (len_v > MAXLEN) ? MAXLEN : len_v;
    for (int i = 0; i < l; i++) begin
      b = mem[(OBUF + i) % MEMSZ];
      exp_addr_q.push_back(ASZ'((OBUF + i) % MEMSZ));
      if (b == 8'h00) return;
      exp_q.push_back(b);
      exp_cnt++;
    end
    end_by_len = (l > 0);
  endfunction

  task automatic fill_rand(input int zero_pct);
    for (int i = OBUF; i < OBUF + 'h800; i++) begin
      if ($urandom_range(99) < zero_pct) mem[i] = 8'h00;
      else mem[i] = 8'($urandom_range(255, 1));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_tx_valid"}, bus.tx_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_mem_a"}, bus.mem_a, 0);
  endtask

  // ---------------- memory responder, sink and monitor ----------------
  initial begin
    bit             pend_v = 0;
    logic [ASZ-1:0] pend_a = '0;
    bit             done_due = 0;
    bit             hold_prev = 0;
    logic [ASZ-1:0] hold_a = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_v = 0; done_due = 0; hold_prev = 0;
        if (bus.done) done_cnt++;
      end else begin
        if (gnt_block > 0 && bus.mem_en) begin
          bus.mem_gnt = 1'b0;
          gnt_block--;
        end else bus.mem_gnt = ($urandom_range(99) < gnt_pct);
        if (rdy_block > 0 && bus.tx_valid) begin
          bus.tx_ready = 1'b0;
          rdy_block--;
        end else bus.tx_ready = ($urandom_range(99) < rdy_pct);
        bus.mem_d = pend_v ? mem[pend_a] : 8'($urandom);
        pend_v = 0;
        if (done_due) chk("done_timing", bus.done, 1);
        done_due = 0;
        if (bus.done) done_cnt++;
        chk("en_valid_excl", bus.mem_en & bus.tx_valid, 0);
        if (hold_prev && bus.mem_en) chk("addr_hold", bus.mem_a, hold_a);
        hold_prev = 0;
        if (bus.mem_en && bus.mem_gnt) begin
          pend_v = 1;
          pend_a = bus.mem_a;
          if (exp_addr_q.size() == 0) chk("rd_unexpected", bus.mem_a, 32'hFFFF_FFFF);
          else chk("rd_addr", bus.mem_a, exp_addr_q.pop_front());
        end else if (bus.mem_en) begin
          hold_prev = 1;
          hold_a    = bus.mem_a;
        end
        if (bus.tx_valid && bus.tx_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) chk("tx_extra", bus.tx_data, 32'h100);
          else begin
            chk("tx_byte", bus.tx_data, exp_q.pop_front());
            if (exp_q.size() == 0 && end_by_len) done_due = 1;
          end
        end else if (bus.tx_valid) begin
          chk("tx_hold", bus.tx_data, (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h100);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input int len_v);
    build_model(len_v);
    done_cnt = 0;
    xfer_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = ASZ'(len_v);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = ASZ'($urandom);
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget, input bit poke_start);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
      if (poke_start && bus.busy && $urandom_range(9) == 0) begin
        bus.start = 1'b1;
        bus.len   = ASZ'($urandom_range(40, 1));
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (i >= budget) chk({tag, "_timeout"}, done_cnt, 1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_idle"}, bus.busy, 0);
    chk({tag, "_count"}, bus.count, exp_cnt);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_reads_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic run_xfer(input string tag, input int len_v, input bit poke_start);
    int l;
    l = (len_v > MAXLEN) ? MAXLEN : len_v;
    start_xfer(len_v);
    wait_done(tag, 10 * l + 50, poke_start);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0; bus.len = '0; bus.mem_gnt = 1'b0;
    bus.mem_d = 8'h00; bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    fill_rand(0);
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    mem[OBUF] = 8'h6F; mem[OBUF+1] = 8'h6B; mem[OBUF+2] = 8'h0A;
    run_xfer("ok_nl", 3, 0);

    mem[OBUF] = 8'h68; mem[OBUF+1] = 8'h69; mem[OBUF+2] = 8'h00; mem[OBUF+3] = 8'h78;
    run_xfer("nul_stop", 4, 0);

    fill_rand(0);
    rdy_block = 5;
    run_xfer("rdy_stall", 2, 0);

    gnt_block = 4;
    run_xfer("gnt_stall", 2, 0);

    run_xfer("len_zero", 0, 0);

    fill_rand(0);
    run_xfer("clamp", 'h700, 1);

    // Abort a transfer with an asynchronous reset after two bytes.
    start_xfer(8);
    for (int i = 0; i < 200 && xfer_cnt < 2; i++) @(negedge clk);
    chk("rst_two_bytes", xfer_cnt, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("mid_reset");
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    #2 rst_n = 1'b1;
    run_xfer("after_reset", 1, 0);

    for (int t = 0; t < 12; t++) begin
      fill_rand(8);
      gnt_pct = $urandom_range(100, 40);
      rdy_pct = $urandom_range(100, 40);
      run_xfer("rand", $urandom_range(40), $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/obuf_reader.md
OBUF_READER -- requirements
Module: obuf_reader

Interface
REQ-001 Parameter OBUF, default 'h1400, output buffer base byte address.
REQ-002 Parameter ASZ, default 17, byte address width.
REQ-003 Parameter MAXLEN, default 'h600, largest accepted transfer length in bytes.
REQ-004 Parameter NUL_STOP, default 1, when 1 a 8'h00 byte ends the transfer early and is not emitted.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  one-cycle request to begin draining; sampled only in IDLE.
REQ-008 len  input  ASZ  byte count, sampled with start.
REQ-009 mem_en  output  1  byte read request to memory.
REQ-010 mem_a  output  ASZ  byte read address.
REQ-011 mem_gnt  input  1  memory grant; a request is accepted on a cycle with mem_en=1 and mem_gnt=1.
REQ-012 mem_d  input  8  read data, valid exactly one cycle after the accepting cycle.
REQ-013 tx_data  output  8  output byte stream.
REQ-014 tx_valid  output  1  tx_data valid.
REQ-015 tx_ready  input  1  sink accept; a byte transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on completion.
REQ-018 count  output  ASZ  number of bytes emitted in the current or last transfer.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT, EMIT and FIN.
REQ-020 IDLE: start=1 with len=0 -> FIN; start=1 with len>MAXLEN -> len SHALL be clamped to MAXLEN, then REQ; otherwise the block SHALL latch len, set the address pointer to OBUF, clear count, and go to REQ.
REQ-021 REQ: mem_en=1 and mem_a=pointer; on mem_gnt=1 -> WAIT; without grant the block SHALL stay in REQ and hold mem_a stable.
REQ-022 WAIT: the block SHALL capture mem_d into tx_data, with mem_en=0; NUL_STOP=1 and mem_d=0 -> FIN; otherwise -> EMIT.
REQ-023 EMIT: tx_valid=1; tx_data and tx_valid SHALL be held stable until tx_ready=1.
REQ-024 On transfer in EMIT: count+1 and pointer+1; if the new count equals the latched len -> FIN, else -> REQ.
REQ-025 Throughput SHALL be at most one byte per 3 cycles with constant grant and ready; prefetch is not required.
REQ-026 The pointer SHALL wrap modulo 2^ASZ; count SHALL never exceed the latched len.
REQ-027 FIN: done=1 for exactly one cycle, then -> IDLE; count SHALL hold its value until the next accepted start.
REQ-028 A start asserted while busy=1 SHALL be ignored, with no effect on the latched len or the pointer.
REQ-029 mem_en SHALL be 0 in every state except REQ; tx_valid SHALL be 0 in every state except EMIT.

Reset
REQ-030 rst_n=0 SHALL force, asynchronously, state=IDLE and mem_en=0, tx_valid=0, busy=0, done=0, count=0, tx_data=0, mem_a=0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no done pulse; the first start after release begins a fresh transfer.

Verification
REQ-032 Memory preloaded with "ok\n" at 'h1400, tx_ready=1, mem_gnt=1, start with len=3 -> bytes 6F,6B,0A out; done one cycle after the last transfer; count=3.
REQ-033 "hi",00,"x" at 'h1400, len=4, NUL_STOP=1 -> 68,69 emitted; done; count=2; no read at 'h1403.
REQ-034 len=2, tx_ready held low for 5 cycles on the first byte -> tx_data stable for all stall cycles, no extra memory read; then both bytes emitted in order.
REQ-035 mem_gnt low for 4 cycles in REQ -> mem_en=1 and mem_a='h1400 held stable; data taken only after the grant cycle.
REQ-036 start with len='h700 -> exactly 'h600 bytes, count='h600; start pulses issued during busy ignored.
REQ-037 rst_n pulsed low after 2 bytes of len=8 -> outputs at reset values immediately, no done; a new start with len=1 emits the byte at 'h1400.
